cpu_reg_slave: RTL and testbench
================================

Name: cpu_reg_slave

Overview:
- Parametrised CPU-bus register slave; next generation of the bus slave side of the CPU interface.
- Generalises data width, word-address width, register count, base address and wait states.
- Adds per-register read-only masking, hardware status inputs, write strobes, access abort on timeout, and error responses.
- Sits behind the CPU bus master. Exposes a flat register bank to datapath logic.

Parameters:
- DATA_W, 32: data bus width in bits.
- ADDR_W, 30: word-address width. The address bus is word-aligned, bits [ADDR_W+1:2].
- NUM_REGS, 8: number of registers (1..256).
- BASE_ADDR, 0: word address of register 0.
- WAIT_STATES, 2: extra cycles inserted before completing a valid access (0..15).
- RO_MASK, 0: NUM_REGS-bit mask. Bit i set means register i is read-only and reads status_in slice i.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- timeout, input, 1: master abort request.
- read, input, 1: read request, held until complete or abort.
- write, input, 1: write request, held until complete or abort.
- write_data, input, DATA_W: write data, stable while write is high.
- address, input, ADDR_W: word address, stable while a request is high.
- read_data, output, DATA_W: read result, valid only while access_complete is high.
- access_complete, output, 1: one-cycle completion pulse.
- invalid_address, output, 1: error flag, pulsed with access_complete.
- invalid_access, output, 1: error flag, pulsed with access_complete.
- status_in, input, NUM_REGS*DATA_W: hardware values for read-only registers. Slice i is bits [i*DATA_W +: DATA_W].
- reg_q, output, NUM_REGS*DATA_W: current contents of read-write registers. Read-only slices drive 0.
- reg_wr, output, NUM_REGS: one-cycle write strobe per register, coincident with access_complete.

Behaviour:
- Reset, asynchronous: all outputs 0, all registers 0, FSM in IDLE, wait counter 0.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: samples read, write and address each cycle. Decode at a rising edge with a request present:
    - read and write both high: invalid_access error.
    - address < BASE_ADDR or address >= BASE_ADDR+NUM_REGS: invalid_address error.
    - write to a register with its RO_MASK bit set: invalid_access error.
    - If both error conditions apply, invalid_address takes priority; only one flag is raised.
    - Error: go to RESP directly, no wait states.
    - Valid request with WAIT_STATES=0: go to RESP.
    - Valid request otherwise: go to WAIT, counter loaded with WAIT_STATES-1.
  - WAIT: counter decrements each cycle; go to RESP when it reaches 0.
    - timeout high in WAIT: go to DONE. No write, no pulse on any output.
  - RESP, one cycle:
    - access_complete=1.
    - Error response: the selected error flag = 1, read_data = 0.
    - Valid read: read_data = register value. Read-only registers return status_in sampled at the edge entering RESP.
    - Valid write: register updated at the edge entering RESP; reg_wr[i]=1 and reg_q reflects the new value in the same cycle.
    - Next state DONE.
  - DONE: waits until read=0 and write=0, then returns to IDLE. Prevents a held request from retriggering. Requests seen in DONE are ignored.
- Latency, request first high in cycle 0 in IDLE:
  - access_complete in cycle 1+WAIT_STATES for a valid access.
  - access_complete in cycle 1 for an error.
- Outside RESP: access_complete, both error flags, reg_wr and read_data are 0.
- timeout is ignored in IDLE, RESP and DONE.
- Address and write_data are captured at the IDLE decode edge. Changes during WAIT have no effect.
- Back-to-back accesses: minimum spacing is RESP, then DONE for one cycle with the request low, then IDLE.
- Reset mid-access: the access is dropped, registers clear, and no completion is ever issued for it.

Test Plan:
- Reset, then write 0xDEADBEEF to BASE_ADDR+3 (WAIT_STATES=2):
  - access_complete in cycle 3, reg_wr=8'b0000_1000, reg_q slice 3=0xDEADBEEF.
  - A following read returns 0xDEADBEEF in cycle 3 with no error flags.
- Read of address BASE_ADDR+NUM_REGS: complete in cycle 1 with invalid_address=1, read_data=0, no reg_wr.
- RO_MASK=8'h01, status_in slice 0=0x12345678:
  - Read reg 0 returns 0x12345678.
  - Write reg 0 completes in cycle 1 with invalid_access=1; reg_q slice 0 remains 0.
- read and write asserted together on a valid address: invalid_access=1 in cycle 1, no register changes.
- Write with timeout pulsed in cycle 1 (WAIT_STATES=2): no access_complete, no reg_wr, register unchanged; FSM returns to IDLE once the request drops.
- Request held for 5 cycles after completion: exactly one access_complete pulse.
- Reset asserted mid-WAIT: all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_reg_slave.sv
// CPU-bus register slave: flat register bank with wait states, read-only
// status registers, write strobes, master abort and error responses.
module cpu_reg_slave #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          ADDR_W      = 30,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          BASE_ADDR   = 0,
  parameter int unsigned          WAIT_STATES = 2,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         timeout,
  input  logic                         read,
  input  logic                         write,
  input  logic [DATA_W-1:0]            write_data,
  input  logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            read_data,
  output logic                         access_complete,
  output logic                         invalid_address,
  output logic                         invalid_access,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr
);

  localparam int unsigned       IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W+1:0] BASE_W   = (ADDR_W+2)'(BASE_ADDR);
  localparam logic [ADDR_W+1:0] END_W    = (ADDR_W+2)'(BASE_ADDR + NUM_REGS);
  localparam logic [3:0]        CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]  cap_idx;
  logic              cap_write;
  logic [DATA_W-1:0] cap_wdata;

  logic [ADDR_W+1:0] addr_ext;
  logic              req;
  logic [IDX_W-1:0]  dec_idx;
  logic              addr_bad;
  logic              acc_bad;
  logic              fire;
  logic [IDX_W-1:0]  op_idx;
  logic              op_write;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] op_rdata;

  // The access executes on a single edge: directly from IDLE when there are
  // no wait states, otherwise from WAIT using the values captured at decode.
  always_comb begin
    addr_ext = {2'b00, address};
    req      = read | write;
    dec_idx  = IDX_W'(addr_ext - BASE_W);
    addr_bad = (addr_ext < BASE_W) || (addr_ext >= END_W);
    acc_bad  = (read && write) || (write && RO_MASK[dec_idx]);
    if (state == S_IDLE) begin
      op_idx   = dec_idx;
      op_write = write;
      op_wdata = write_data;
    end else begin
      op_idx   = cap_idx;
      op_write = cap_write;
      op_wdata = cap_wdata;
    end
    fire = ((state == S_IDLE) && req && !addr_bad && !acc_bad && (WAIT_STATES == 0)) ||
           ((state == S_WAIT) && !timeout && (cnt == 4'd0));
    op_rdata = RO_MASK[op_idx] ? status_in[int'(op_idx)*DATA_W +: DATA_W] : regs[op_idx];
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      cap_idx         <= '0;
      cap_write       <= 1'b0;
      cap_wdata       <= '0;
      read_data       <= '0;
      access_complete <= 1'b0;
      invalid_address <= 1'b0;
      invalid_access  <= 1'b0;
      reg_wr          <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      access_complete <= 1'b0;
      invalid_address <= 1'b0;
      invalid_access  <= 1'b0;
      reg_wr          <= '0;
      read_data       <= '0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_idx   <= dec_idx;
            cap_write <= write;
            cap_wdata <= write_data;
            cnt       <= CNT_LOAD;
            if (addr_bad) begin
              state           <= S_RESP;
              access_complete <= 1'b1;
              invalid_address <= 1'b1;
            end else if (acc_bad) begin
              state           <= S_RESP;
              access_complete <= 1'b1;
              invalid_access  <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (timeout)
            state <= S_DONE;
          else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
        end
        S_RESP: state <= S_DONE;
        S_DONE: if (!req) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (fire) begin
        state           <= S_RESP;
        access_complete <= 1'b1;
        if (op_write) begin
          regs[op_idx]   <= op_wdata;
          reg_wr[op_idx] <= 1'b1;
        end else begin
          read_data <= op_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_reg_slave.sv
// Directed self-checking bench for cpu_reg_slave (BASE=16, 8 regs, 2 wait states, reg 0 read-only).
module tb_cpu_reg_slave;

  localparam logic [29:0] BASE = 30'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        timeout = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] write_data = '0;
  logic [29:0] address = '0;
  logic [31:0] read_data;
  logic        access_complete;
  logic        invalid_address;
  logic        invalid_access;
  logic [255:0] status_in = '0;
  logic [255:0] reg_q;
  logic [7:0]  reg_wr;

  int total = 0;
  int bad = 0;

  cpu_reg_slave #(
    .DATA_W(32), .ADDR_W(30), .NUM_REGS(8), .BASE_ADDR(16),
    .WAIT_STATES(2), .RO_MASK(8'h01)
  ) dut (
    .clk(clk), .reset(reset), .timeout(timeout), .read(read), .write(write),
    .write_data(write_data), .address(address), .read_data(read_data),
    .access_complete(access_complete), .invalid_address(invalid_address),
    .invalid_access(invalid_access), .status_in(status_in), .reg_q(reg_q),
    .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  // Drives one request from an IDLE cycle, records the completion cycle and
  // outputs, then releases the request and waits out DONE back to IDLE.
  task automatic do_access(input logic r, input logic w, input logic [29:0] a,
                           input logic [31:0] d, output int cyc, output logic [31:0] rd,
                           output logic ia, output logic ie, output logic [7:0] wr);
    read = r; write = w; address = a; write_data = d;
    cyc = -1; rd = '0; ia = 1'b0; ie = 1'b0; wr = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (access_complete) begin
        cyc = k; rd = read_data; ia = invalid_address; ie = invalid_access; wr = reg_wr;
        break;
      end
    end
    read = 1'b0; write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (access_complete !== 1'b0) begin bad++; $display("FAIL rst_ac got=%b exp=0", access_complete); end
    total++; if ({invalid_address, invalid_access} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {invalid_address, invalid_access}); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", read_data); end
    total++; if (reg_wr !== 8'h00) begin bad++; $display("FAIL rst_wr got=%h exp=00", reg_wr); end
    total++; if (reg_q !== 256'h0) begin bad++; $display("FAIL rst_q got=%h exp=0", reg_q); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int cyc; logic [31:0] rd; logic ia, ie; logic [7:0] wr;
    do_access(1'b0, 1'b1, BASE + 30'd3, 32'hDEADBEEF, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 3) begin bad++; $display("FAIL wr_lat got=%0d exp=3", cyc); end
    total++; if (wr !== 8'b0000_1000) begin bad++; $display("FAIL wr_strobe got=%b exp=00001000", wr); end
    total++; if ({ia, ie} !== 2'b00) begin bad++; $display("FAIL wr_err got=%b exp=00", {ia, ie}); end
    total++; if (reg_q[3*32 +: 32] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_q3 got=%h exp=deadbeef", reg_q[3*32 +: 32]); end
    do_access(1'b1, 1'b0, BASE + 30'd3, 32'h0, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 3) begin bad++; $display("FAIL rd_lat got=%0d exp=3", cyc); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    total++; if ({ia, ie, wr} !== 10'h0) begin bad++; $display("FAIL rd_flags got=%b exp=0", {ia, ie, wr}); end
  endtask

  task automatic test_bad_address();
    int cyc; logic [31:0] rd; logic ia, ie; logic [7:0] wr;
    do_access(1'b1, 1'b0, BASE + 30'd8, 32'h0, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 1) begin bad++; $display("FAIL hi_lat got=%0d exp=1", cyc); end
    total++; if ({ia, ie} !== 2'b10) begin bad++; $display("FAIL hi_err got=%b exp=10", {ia, ie}); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL hi_rd got=%h exp=0", rd); end
    total++; if (wr !== 8'h00) begin bad++; $display("FAIL hi_wr got=%h exp=00", wr); end
    do_access(1'b0, 1'b1, BASE - 30'd1, 32'h1111, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 1 || {ia, ie} !== 2'b10) begin bad++; $display("FAIL lo_err got=%0d/%b exp=1/10", cyc, {ia, ie}); end
    total++; if (wr !== 8'h00) begin bad++; $display("FAIL lo_wr got=%h exp=00", wr); end
  endtask

  task automatic test_read_only();
    int cyc; logic [31:0] rd; logic ia, ie; logic [7:0] wr;
    do_access(1'b1, 1'b0, BASE, 32'h0, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 3) begin bad++; $display("FAIL ro_rd_lat got=%0d exp=3", cyc); end
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL ro_rd got=%h exp=12345678", rd); end
    do_access(1'b0, 1'b1, BASE, 32'hFFFFFFFF, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 1) begin bad++; $display("FAIL ro_wr_lat got=%0d exp=1", cyc); end
    total++; if ({ia, ie} !== 2'b01) begin bad++; $display("FAIL ro_wr_err got=%b exp=01", {ia, ie}); end
    total++; if (wr !== 8'h00) begin bad++; $display("FAIL ro_wr_strobe got=%h exp=00", wr); end
    total++; if (reg_q[31:0] !== 32'h0) begin bad++; $display("FAIL ro_q0 got=%h exp=0", reg_q[31:0]); end
  endtask

  task automatic test_read_write_both();
    int cyc; logic [31:0] rd; logic ia, ie; logic [7:0] wr;
    do_access(1'b1, 1'b1, BASE + 30'd3, 32'h0BAD0BAD, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 1) begin bad++; $display("FAIL both_lat got=%0d exp=1", cyc); end
    total++; if ({ia, ie} !== 2'b01) begin bad++; $display("FAIL both_err got=%b exp=01", {ia, ie}); end
    total++; if (wr !== 8'h00) begin bad++; $display("FAIL both_wr got=%h exp=00", wr); end
    total++; if (reg_q[3*32 +: 32] !== 32'hDEADBEEF) begin bad++; $display("FAIL both_q3 got=%h exp=deadbeef", reg_q[3*32 +: 32]); end
    do_access(1'b1, 1'b1, BASE + 30'd8, 32'h0, cyc, rd, ia, ie, wr);
    total++; if ({ia, ie} !== 2'b10) begin bad++; $display("FAIL prio_err got=%b exp=10", {ia, ie}); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int cyc; logic [31:0] rd; logic ia, ie; logic [7:0] wr;
    write = 1'b1; address = BASE + 30'd5; write_data = 32'h00000055;
    @(posedge clk); #1;
    timeout = 1'b1;
    @(posedge clk); #1;
    timeout = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (access_complete || reg_wr != 8'h00 || read_data != 32'h0) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL to_pulse got=%0d exp=0", pulses); end
    write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (reg_q[5*32 +: 32] !== 32'h0) begin bad++; $display("FAIL to_q5 got=%h exp=0", reg_q[5*32 +: 32]); end
    do_access(1'b1, 1'b0, BASE + 30'd5, 32'h0, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 3 || rd !== 32'h0) begin bad++; $display("FAIL to_recover got=%0d/%h exp=3/0", cyc, rd); end
  endtask

  task automatic test_held_request();
    int pulses = 0;
    int strobes = 0;
    write = 1'b1; address = BASE + 30'd1; write_data = 32'h0BADF00D;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (access_complete) pulses++;
      if (reg_wr != 8'h00) strobes++;
    end
    write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (pulses !== 1) begin bad++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    total++; if (strobes !== 1) begin bad++; $display("FAIL held_strobes got=%0d exp=1", strobes); end
    total++; if (reg_q[1*32 +: 32] !== 32'h0BADF00D) begin bad++; $display("FAIL held_q1 got=%h exp=0badf00d", reg_q[1*32 +: 32]); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] rd; logic ia, ie; logic [7:0] wr;
    do_access(1'b0, 1'b1, BASE + 30'd2, 32'hCAFEF00D, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 3 || wr !== 8'b0000_0100) begin bad++; $display("FAIL b2b_wr got=%0d/%b exp=3/00000100", cyc, wr); end
    do_access(1'b1, 1'b0, BASE + 30'd2, 32'h0, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 3 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rd got=%0d/%h exp=3/cafef00d", cyc, rd); end
    do_access(1'b1, 1'b0, BASE + 30'd7, 32'h0, cyc, rd, ia, ie, wr);
    total++; if (cyc !== 3 || rd !== 32'h0) begin bad++; $display("FAIL b2b_rd7 got=%0d/%h exp=3/0", cyc, rd); end
  endtask

  task automatic test_reset_mid_access();
    int pulses = 0;
    write = 1'b1; address = BASE + 30'd6; write_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    #2;
    reset = 1'b1; write = 1'b0;
    #1;
    total++; if ({access_complete, invalid_address, invalid_access, reg_wr} !== 11'h0) begin bad++; $display("FAIL mid_outs got=%h exp=0", {access_complete, invalid_address, invalid_access, reg_wr}); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL mid_rd got=%h exp=0", read_data); end
    total++; if (reg_q !== 256'h0) begin bad++; $display("FAIL mid_q got=%h exp=0", reg_q); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (access_complete || reg_wr != 8'h00) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_pulse got=%0d exp=0", pulses); end
    total++; if (reg_q[6*32 +: 32] !== 32'h0) begin bad++; $display("FAIL mid_q6 got=%h exp=0", reg_q[6*32 +: 32]); end
  endtask

  initial begin
    status_in[0*32 +: 32] = 32'h12345678;
    status_in[3*32 +: 32] = 32'hFFFF0000;
    status_in[5*32 +: 32] = 32'h0F0F0F0F;
    test_reset();
    test_write_read();
    test_bad_address();
    test_read_only();
    test_read_write_both();
    test_timeout();
    test_held_request();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
